sync_debounce_bank: RTL and testbench
=====================================

SYNC_DEBOUNCE_BANK -- requirements
Module: sync_debounce_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent input channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: flip-flop synchronizer depth (2..4).
REQ-003 SHALL have parameter DB_CYCLES, default 4: consecutive stable cycles required before accepting a new level (1..255).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-005 SHALL have port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port async_in, input, N_CH bits: asynchronous raw inputs (sensor, walk request, reprogram, ...).
REQ-007 SHALL have port ack, input, N_CH bits: per-channel clear for req_latched; synchronous to clk.
REQ-008 SHALL have port sync_out, output, N_CH bits: synchronized and debounced level.
REQ-009 SHALL have port rise_pulse, output, N_CH bits: one-cycle pulse on each 0->1 change of sync_out.
REQ-010 SHALL have port fall_pulse, output, N_CH bits: one-cycle pulse on each 1->0 change of sync_out.
REQ-011 SHALL have port req_latched, output, N_CH bits: sticky request, set by rise_pulse and cleared by ack.

Function
REQ-012 SHALL pass each async_in bit through a SYNC_STAGES-deep register chain; the last stage is s_in[ch].
REQ-013 SHALL keep a per-channel counter cnt, width ceil(log2(DB_CYCLES+1)), that increments while s_in != sync_out and clears to 0 in any cycle where s_in == sync_out.
REQ-014 SHALL, when s_in != sync_out and cnt == DB_CYCLES-1, load sync_out <= s_in on that edge and clear cnt to 0.
REQ-015 SHALL give a latency of SYNC_STAGES + DB_CYCLES clk edges from a stable async_in change to the sync_out change.
REQ-016 SHALL ignore (leave sync_out unchanged and restart the count for) any glitch at s_in that is shorter than DB_CYCLES cycles.
REQ-017 SHALL register rise_pulse and fall_pulse so that they are high during exactly the first cycle in which sync_out shows the new level; both SHALL never be high together for the same channel.
REQ-018 SHALL set req_latched[ch] on the edge after rise_pulse[ch], and clear it on any edge where ack[ch]=1 and rise_pulse[ch]=0.
REQ-019 SHALL keep req_latched[ch] set when ack[ch] and rise_pulse[ch] are asserted in the same cycle (set wins).
REQ-020 SHALL treat channels as fully independent; the activity of one channel SHALL NOT affect another channel.

Reset
REQ-021 SHALL, on any clk edge with Reset=1, clear all synchronizer stages, cnt, sync_out, rise_pulse, fall_pulse and req_latched to 0.
REQ-022 SHALL, when Reset is asserted mid-debounce, abandon that debounce; an input held high through reset release SHALL produce rise_pulse SYNC_STAGES+DB_CYCLES edges after the first edge with Reset=0.
REQ-023 SHALL ignore ack and async_in while Reset=1.

Configuration
REQ-024 SHALL implement the debounce counter of REQ-013/014 only when the macro SYNC_DEBOUNCE_EN is defined.
REQ-025 SHALL, without SYNC_DEBOUNCE_EN, set sync_out = s_in registered with no filtering, giving a latency of SYNC_STAGES edges, with no counter logic instantiated and DB_CYCLES unused.

Structure
REQ-026 SHALL place the default parameter values, the SYNC_STAGES limits and the counter-width function in the shared package sync_pkg.
REQ-027 SHALL implement one channel (synchronizer, debounce, edge detect, latch) in sub-module sync_chan, generated N_CH times.

Verification (N_CH=4, SYNC_STAGES=2, DB_CYCLES=4, 10 ns clk)
REQ-028 SHALL verify: Reset=1 for 2 edges with async_in=4'hF -> all outputs 0; after release, sync_out=4'hF at edge 6, rise_pulse=4'hF for one cycle, req_latched=4'hF at edge 7.
REQ-029 SHALL verify: async_in[1] pulsed high for 3 cycles -> sync_out[1], rise_pulse[1] and req_latched[1] stay 0.
REQ-030 SHALL verify: async_in[2] 1->0 held -> fall_pulse[2] high exactly one cycle, 6 edges later; req_latched[2] unchanged.
REQ-031 SHALL verify: ack[0]=1 in the same cycle as rise_pulse[0] -> req_latched[0]=1; ack[0]=1 on the next cycle -> req_latched[0]=0.
REQ-032 SHALL verify: Reset asserted at cnt=2 on channel 3 -> cnt=0 and sync_out[3]=0; the full 6-edge latency restarts after release.
REQ-033 SHALL verify: with SYNC_DEBOUNCE_EN undefined, a step on async_in[0] -> sync_out[0] changes 2 edges later and a 1-cycle glitch propagates.

Source files
------------

// File: rtl/sync_pkg.sv
// Shared defaults, synchronizer depth limits and counter sizing for sync_debounce_bank.
// Debounce filtering is selected with the SYNC_DEBOUNCE_EN macro.
package sync_pkg;

   localparam int DEF_N_CH        = 4;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_DB_CYCLES   = 4;
   localparam int SYNC_STAGES_MIN = 2;
   localparam int SYNC_STAGES_MAX = 4;

   // Counter must hold values 0..DB_CYCLES, so it needs ceil(log2(DB_CYCLES+1)) bits.
   function automatic int cnt_width(input int db);
      if (db < 1)
         return 1;
      return $clog2(db + 1);
   endfunction

   function automatic int sync_depth(input int stages);
      if (stages < SYNC_STAGES_MIN)
         return SYNC_STAGES_MIN;
      if (stages > SYNC_STAGES_MAX)
         return SYNC_STAGES_MAX;
      return stages;
   endfunction

endpackage

// File: rtl/sync_chan.sv
// One channel: synchronizer, optional debounce (SYNC_DEBOUNCE_EN), edge pulses and sticky request.
// Without SYNC_DEBOUNCE_EN the last synchronizer stage drives sync_out directly.
module sync_chan
   import sync_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int DB_CYCLES   = DEF_DB_CYCLES
) (
   input  logic clk,
   input  logic Reset,
   input  logic async_in,
   input  logic ack,
   output logic sync_out,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic req_latched
);

   localparam int STAGES = sync_depth(SYNC_STAGES);

   logic [STAGES-1:0] r_sync;
   logic              r_rise;
   logic              r_fall;
   logic              r_req;
   logic              w_sIn;

   assign w_sIn = r_sync[STAGES-1];

   always_ff @(posedge clk) begin
      if (Reset)
         r_sync <= '0;
      else
         r_sync <= {r_sync[STAGES-2:0], async_in};
   end

`ifdef SYNC_DEBOUNCE_EN
   localparam int CNT_W = cnt_width(DB_CYCLES);

   logic [CNT_W-1:0] r_cnt;
   logic             r_level;
   logic             w_differ;
   logic             w_load;

   assign w_differ = (w_sIn != r_level);
   assign w_load   = w_differ && (r_cnt == CNT_W'(DB_CYCLES - 1));

   // The counter restarts whenever s_in agrees with the accepted level, so short glitches never load.
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         if (!w_differ || w_load)
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + 1'b1;
         if (w_load)
            r_level <= w_sIn;
         r_rise <= w_load && w_sIn;
         r_fall <= w_load && !w_sIn;
      end
   end

   assign sync_out = r_level;
`else
   // Pulses are computed from the stage feeding s_in so they line up with the new sync_out level.
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_rise <= r_sync[STAGES-2] && !w_sIn;
         r_fall <= !r_sync[STAGES-2] && w_sIn;
      end
   end

   assign sync_out = w_sIn;
`endif

   // A rise in the same cycle as ack keeps the request set.
   always_ff @(posedge clk) begin
      if (Reset)
         r_req <= 1'b0;
      else
         r_req <= r_rise || (r_req && !ack);
   end

   assign rise_pulse  = r_rise;
   assign fall_pulse  = r_fall;
   assign req_latched = r_req;

endmodule

// File: rtl/sync_debounce_bank.sv
// Bank of N_CH independent synchronize/debounce/edge-detect channels.
// Debounce filtering is enabled by defining SYNC_DEBOUNCE_EN.
module sync_debounce_bank
   import sync_pkg::*;
#(
   parameter int N_CH        = DEF_N_CH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int DB_CYCLES   = DEF_DB_CYCLES
) (
   input  logic            clk,
   input  logic            Reset,
   input  logic [N_CH-1:0] async_in,
   input  logic [N_CH-1:0] ack,
   output logic [N_CH-1:0] sync_out,
   output logic [N_CH-1:0] rise_pulse,
   output logic [N_CH-1:0] fall_pulse,
   output logic [N_CH-1:0] req_latched
);

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
      sync_chan #(
         .SYNC_STAGES (SYNC_STAGES),
         .DB_CYCLES   (DB_CYCLES)
      ) u_chan (
         .clk         (clk),
         .Reset       (Reset),
         .async_in    (async_in[gi]),
         .ack         (ack[gi]),
         .sync_out    (sync_out[gi]),
         .rise_pulse  (rise_pulse[gi]),
         .fall_pulse  (fall_pulse[gi]),
         .req_latched (req_latched[gi])
      );
   end

endmodule

// File: tb/tb_sync_debounce_bank.sv
// Directed bench for sync_debounce_bank (N_CH=4, SYNC_STAGES=2, DB_CYCLES=4); follows SYNC_DEBOUNCE_EN.
module tb_sync_debounce_bank;

`ifdef SYNC_DEBOUNCE_EN
   localparam int LAT = 6;
`else
   localparam int LAT = 2;
`endif

   typedef struct {
      logic       rst;
      logic [3:0] in;
      logic [3:0] ackV;
      logic [3:0] expSync;
      logic [3:0] expRise;
      logic [3:0] expFall;
      logic [3:0] expReq;
   } vec_t;

   logic       clk;
   logic       Reset;
   logic [3:0] async_in;
   logic [3:0] ack;
   logic [3:0] sync_out;
   logic [3:0] rise_pulse;
   logic [3:0] fall_pulse;
   logic [3:0] req_latched;

   int compared   = 0;
   int mismatched = 0;

   vec_t vecs [10];

   sync_debounce_bank #(
      .N_CH        (4),
      .SYNC_STAGES (2),
      .DB_CYCLES   (4)
   ) dut (
      .clk         (clk),
      .Reset       (Reset),
      .async_in    (async_in),
      .ack         (ack),
      .sync_out    (sync_out),
      .rise_pulse  (rise_pulse),
      .fall_pulse  (fall_pulse),
      .req_latched (req_latched)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [3:0] got, input logic [3:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   // Drives one cycle of inputs and returns 1 ns after the following rising edge.
   task automatic applyStimulus(input logic rst, input logic [3:0] inV, input logic [3:0] ackV);
      Reset    = rst;
      async_in = inV;
      ack      = ackV;
      @(posedge clk);
      #1;
   endtask

   task automatic runGlitch(input string name, input logic [3:0] base, input logic [3:0] mask,
                            input int width, input int a, input int b);
      logic [3:0] inV;
      applyStimulus(1'b0, base, mask);
      checkOutput({name, "_preack"}, req_latched & mask, 4'h0);
      for (int e = 1; e <= 16; e++) begin
         inV = (e <= width) ? (base | mask) : base;
         applyStimulus(1'b0, inV, 4'h0);
         checkOutput({name, "_sync"}, sync_out & mask,
                     (a > 0 && e >= a && e <= b) ? mask : 4'h0);
         checkOutput({name, "_rise"}, rise_pulse & mask, (a > 0 && e == a) ? mask : 4'h0);
         checkOutput({name, "_fall"}, fall_pulse & mask, (a > 0 && e == b + 1) ? mask : 4'h0);
         checkOutput({name, "_req"}, req_latched & mask, (a > 0 && e > a) ? mask : 4'h0);
      end
   endtask

   initial begin
      Reset    = 1'b1;
      async_in = 4'hF;
      ack      = 4'h0;

      // Reset for two edges with all inputs high, then release and watch the first acceptance.
      vecs[0] = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      vecs[1] = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
`ifdef SYNC_DEBOUNCE_EN
      vecs[2] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      vecs[3] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      vecs[4] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      vecs[5] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      vecs[6] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      vecs[7] = '{1'b0, 4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0};
      vecs[8] = '{1'b0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF};
      vecs[9] = '{1'b0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF};
`else
      vecs[2] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      vecs[3] = '{1'b0, 4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0};
      vecs[4] = '{1'b0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF};
      vecs[5] = '{1'b0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF};
      vecs[6] = '{1'b0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF};
      vecs[7] = '{1'b0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF};
      vecs[8] = '{1'b0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF};
      vecs[9] = '{1'b0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF};
`endif

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].in, vecs[i].ackV);
         checkOutput($sformatf("vec%0d_sync", i), sync_out,    vecs[i].expSync);
         checkOutput($sformatf("vec%0d_rise", i), rise_pulse,  vecs[i].expRise);
         checkOutput($sformatf("vec%0d_fall", i), fall_pulse,  vecs[i].expFall);
         checkOutput($sformatf("vec%0d_req",  i), req_latched, vecs[i].expReq);
      end

      // Channel 2 drops and stays low: one fall pulse after the full latency, requests untouched.
      for (int e = 1; e <= LAT + 2; e++) begin
         applyStimulus(1'b0, 4'hB, 4'h0);
         checkOutput("ch2fall_sync", sync_out,    (e >= LAT) ? 4'hB : 4'hF);
         checkOutput("ch2fall_fall", fall_pulse,  (e == LAT) ? 4'h4 : 4'h0);
         checkOutput("ch2fall_rise", rise_pulse,  4'h0);
         checkOutput("ch2fall_req",  req_latched, 4'hF);
      end

      // Clear all requests, take channel 0 low, then raise it and ack during its rise pulse.
      applyStimulus(1'b0, 4'hB, 4'hF);
      checkOutput("ackall_req", req_latched, 4'h0);
      for (int e = 1; e <= LAT + 1; e++)
         applyStimulus(1'b0, 4'hA, 4'h0);
      checkOutput("ch0low_sync", sync_out, 4'hA);
      for (int e = 1; e <= LAT; e++) begin
         applyStimulus(1'b0, 4'hB, 4'h0);
         checkOutput("ch0rise_rise", rise_pulse,  (e == LAT) ? 4'h1 : 4'h0);
         checkOutput("ch0rise_req",  req_latched, 4'h0);
      end
      applyStimulus(1'b0, 4'hB, 4'h1);
      checkOutput("ackrise_req",  req_latched, 4'h1);
      checkOutput("ackrise_rise", rise_pulse,  4'h0);
      applyStimulus(1'b0, 4'hB, 4'h1);
      checkOutput("acknext_req", req_latched, 4'h0);

      // Channel 1 low, then glitches of several widths.
      for (int e = 1; e <= LAT + 1; e++)
         applyStimulus(1'b0, 4'h9, 4'h0);
      checkOutput("ch1low_sync", sync_out, 4'h9);
`ifdef SYNC_DEBOUNCE_EN
      runGlitch("glitch3", 4'h9, 4'h2, 3, 0, 0);
      runGlitch("glitch1", 4'h9, 4'h2, 1, 0, 0);
      runGlitch("glitch4", 4'h9, 4'h2, 4, 6, 9);
`else
      runGlitch("glitch3", 4'h9, 4'h2, 3, 2, 4);
      runGlitch("glitch1", 4'h9, 4'h2, 1, 2, 2);
      runGlitch("glitch4", 4'h9, 4'h2, 4, 2, 5);
`endif

      // Channel 3 low, then reset two cycles into its rise debounce; latency restarts.
      for (int e = 1; e <= LAT + 1; e++)
         applyStimulus(1'b0, 4'h1, 4'h0);
      checkOutput("ch3low_sync", sync_out, 4'h1);
      for (int e = 1; e <= 4; e++) begin
         applyStimulus(1'b0, 4'h9, 4'h0);
         checkOutput("ch3pre_sync", sync_out, (e >= LAT) ? 4'h9 : 4'h1);
      end
      applyStimulus(1'b1, 4'h9, 4'hF);
      checkOutput("midrst_sync", sync_out,    4'h0);
      checkOutput("midrst_rise", rise_pulse,  4'h0);
      checkOutput("midrst_fall", fall_pulse,  4'h0);
      checkOutput("midrst_req",  req_latched, 4'h0);
      for (int e = 1; e <= LAT + 1; e++) begin
         applyStimulus(1'b0, 4'h9, 4'h0);
         checkOutput("postrst_sync", sync_out,    (e >= LAT) ? 4'h9 : 4'h0);
         checkOutput("postrst_rise", rise_pulse,  (e == LAT) ? 4'h9 : 4'h0);
         checkOutput("postrst_req",  req_latched, (e > LAT)  ? 4'h9 : 4'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
